fetch: RTL and testbench

//   Instruction-fetch stage directly upstream of decode. Holds the fetch PC and

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch.sv | 143 ++++++++++++++
 tb/tb_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem req/gnt + rvalid, redirect from resolution, and {PC,Inst} valid/ready to decode.
// No logic; master is the fetch stage, slave is the surrounding memory/decode/redirect environment.
interface fetch_if;
  logic        o_IMemReq;
  logic [63:0] o_IMemAddr_64;
  logic        i_IMemGnt;
  logic        i_IMemRValid;
  logic [31:0] i_IMemRData_32;
  logic        i_Redirect;
  logic [63:0] i_RedirectPC_64;
  logic        o_Valid;
  logic        i_Ready;
  logic [63:0] o_PC_64;
  logic [31:0] o_Inst_32;

  modport master (
    output o_IMemReq, o_IMemAddr_64, o_Valid, o_PC_64, o_Inst_32,
    input  i_IMemGnt, i_IMemRValid, i_IMemRData_32, i_Redirect, i_RedirectPC_64, i_Ready
  );

  modport slave (
    input  o_IMemReq, o_IMemAddr_64, o_Valid, o_PC_64, o_Inst_32,
    output i_IMemGnt, i_IMemRValid, i_IMemRData_32, i_Redirect, i_RedirectPC_64, i_Ready
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: credit-limited imem reads, in-order response buffer, {PC,Inst} to decode; gnt->o_Valid >= 2 cycles.
// Requests stop while outstanding+buffered reaches DEPTH; rvalid is never stalled; redirect flushes and drops in-flight words.

module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop_rdy && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)   rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push_vld) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset: contents are only observed when count != 0.
  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input logic      i_Clk,
  input logic      i_Rst_n,
  fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [63:0]   redirect_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_sum;
  logic          req;
  logic          fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          out_vld;
  entry_t        push_ent;
  entry_t        head;

  assign redirect_pc = bus.i_RedirectPC_64 & ~64'h3;
  assign credit_sum  = {1'b0, outstanding} + {1'b0, fifo_count};
  // Reset gate keeps the request low while held in reset.
  assign req      = i_Rst_n && !bus.i_Redirect && (credit_sum < (CW+1)'(DEPTH));
  assign fire     = req && bus.i_IMemGnt;
  assign rsp_drop = (drop_cnt != '0);
  assign push     = bus.i_IMemRValid && !rsp_drop && !bus.i_Redirect;
  assign out_vld  = (fifo_count != '0);
  assign pop      = out_vld && bus.i_Ready;
  assign push_ent = '{pc: resp_pc, inst: bus.i_IMemRData_32};

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(bus.i_IMemRValid);
      if (bus.i_Redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        // Everything still in flight after this cycle's response belongs to the old path.
        drop_cnt <= outstanding - CW'(bus.i_IMemRValid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 64'd4;
        if (push) resp_pc  <= resp_pc + 64'd4;
        if (bus.i_IMemRValid && rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .flush    (bus.i_Redirect),
    .push_vld (push),
    .push_dat (push_ent),
    .pop_rdy  (pop),
    .head_dat (head),
    .count    (fifo_count)
  );

  assign bus.o_IMemReq     = req;
  assign bus.o_IMemAddr_64 = fetch_pc;
  assign bus.o_Valid       = out_vld;
  assign bus.o_PC_64       = out_vld ? head.pc   : 64'h0;
  assign bus.o_Inst_32     = out_vld ? head.inst : 32'h0;

  a_credit: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    credit_sum <= (CW+1)'(DEPTH));
  a_rvalid: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    bus.i_IMemRValid |-> (outstanding != '0));
  a_align: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    bus.o_IMemAddr_64[1:0] == 2'b00);
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: randomized memory/decode/redirect environment against an in-order, transaction-level reference model.
module tb_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_if bus();

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] addr; bit stale; } infl_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;

  mreq_t       mem_q[$];   // memory side: granted reads awaiting response
  infl_t       m_infl[$];  // model: reads in flight, stale once a redirect passes them
  ent_t        m_out[$];   // model: instructions decode should see, in order
  logic [63:0] m_pc;
  logic [63:0] popped[$];
  logic [63:0] granted[$];

  bit          k_rdy, k_redir;
  logic [63:0] k_target;
  int          k_gnt_pct, k_lat_min, k_lat_max;

  bit           o_req, o_vld, o_fire, o_rv;
  logic [63:0]  o_addr, o_pc;
  logic [31:0]  o_inst;
  logic [161:0] obs_vec, exp_vec;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  task automatic drive_idle();
    bus.i_IMemGnt       = 1'b0;
    bus.i_IMemRValid    = 1'b0;
    bus.i_IMemRData_32  = 32'h0;
    bus.i_Redirect      = 1'b0;
    bus.i_RedirectPC_64 = 64'h0;
    bus.i_Ready         = 1'b0;
    k_redir = 1'b0;
  endtask

  task automatic model_reset();
    mem_q.delete();
    m_infl.delete();
    m_out.delete();
    m_pc = RESET_PC;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, capture outputs and model expectations, then advance DUT and model.
  task automatic cycle();
    bit          gnt, exp_req, exp_vld;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    infl_t       r;
    @(negedge clk);
    bus.i_Redirect      = k_redir;
    bus.i_RedirectPC_64 = k_target;
    bus.i_Ready         = k_rdy;
    o_rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.i_IMemRValid   = o_rv;
    bus.i_IMemRData_32 = o_rv ? mem_word(mem_q[0].addr) : 32'h0;
    #1;
    o_req  = bus.o_IMemReq;
    o_addr = bus.o_IMemAddr_64;
    o_vld  = bus.o_Valid;
    o_pc   = bus.o_PC_64;
    o_inst = bus.o_Inst_32;
    gnt    = o_req && ($urandom_range(99) < k_gnt_pct);
    o_fire = gnt;
    bus.i_IMemGnt = gnt;
    exp_req  = !k_redir && ((m_infl.size() + m_out.size()) < DEPTH);
    exp_vld  = (m_out.size() > 0);
    exp_pc   = exp_vld ? m_out[0].pc   : 64'h0;
    exp_inst = exp_vld ? m_out[0].inst : 32'h0;
    obs_vec  = {o_req, o_req ? o_addr : 64'h0, o_vld, o_pc, o_inst};
    exp_vec  = {exp_req, exp_req ? m_pc : 64'h0, exp_vld, exp_pc, exp_inst};
    @(posedge clk);
    if (o_rv) void'(mem_q.pop_front());
    if (gnt) begin
      mem_q.push_back('{o_addr, cyc + int'($urandom_range(k_lat_max, k_lat_min))});
      granted.push_back(o_addr);
    end
    if (o_vld && k_rdy && !k_redir) popped.push_back(o_pc);
    if (k_redir) m_out.delete();
    else if (k_rdy && m_out.size() > 0) void'(m_out.pop_front());
    if (o_rv && m_infl.size() > 0) begin
      r = m_infl.pop_front();
      if (!r.stale && !k_redir) m_out.push_back('{r.addr, mem_word(r.addr)});
    end
    if (gnt) begin
      m_infl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 64'd4;
    end
    if (k_redir) begin
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_pc = k_target & ~64'h3;
    end
    cyc++;
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    #3;
    checks++; if (bus.o_IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req act=%b exp=0", bus.o_IMemReq); end
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", bus.o_Valid); end
    checks++; if (bus.o_PC_64 !== 64'h0) begin errors++; $display("FAIL reset_pc act=%h exp=0", bus.o_PC_64); end
    checks++; if (bus.o_Inst_32 !== 32'h0) begin errors++; $display("FAIL reset_inst act=%h exp=0", bus.o_Inst_32); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int first_gnt = -1;
    int first_vld = -1;
    apply_reset();
    popped.delete(); granted.delete();
    k_rdy = 1; k_redir = 0; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL stream_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
      if (o_fire && first_gnt < 0) first_gnt = i;
      if (o_vld && first_vld < 0) first_vld = i;
    end
    checks++; if (first_vld - first_gnt != 2) begin errors++; $display("FAIL stream_latency act=%0d exp=2", first_vld - first_gnt); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (granted[j] !== RESET_PC + 64'(4 * j)) begin errors++; $display("FAIL stream_addr%0d act=%h exp=%h", j, granted[j], RESET_PC + 64'(4 * j)); end
    end
    foreach (popped[j]) begin
      checks++; if (popped[j] !== RESET_PC + 64'(4 * j)) begin errors++; $display("FAIL stream_order%0d act=%h exp=%h", j, popped[j], RESET_PC + 64'(4 * j)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    popped.delete(); granted.delete();
    k_rdy = 0; k_redir = 0; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_hold_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
    end
    checks++; if (granted.size() != DEPTH) begin errors++; $display("FAIL bp_grants act=%0d exp=%0d", granted.size(), DEPTH); end
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req_low act=%b exp=0", o_req); end
    k_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_drain_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
    end
    checks++; if (popped.size() < 4) begin errors++; $display("FAIL bp_drain_count act=%0d exp>=4", popped.size()); end
    foreach (popped[j]) begin
      checks++; if (popped[j] !== RESET_PC + 64'(4 * j)) begin errors++; $display("FAIL bp_order%0d act=%h exp=%h", j, popped[j], RESET_PC + 64'(4 * j)); end
    end
  endtask

  task automatic test_redirect_outstanding();
    bit seen = 0;
    apply_reset();
    k_rdy = 1; k_redir = 0; k_gnt_pct = 100; k_lat_min = 3; k_lat_max = 3;
    for (int i = 0; i < 10 && m_infl.size() < 2; i++) cycle();
    checks++; if (m_infl.size() != 2) begin errors++; $display("FAIL redir_setup act=%0d exp=2", m_infl.size()); end
    k_redir = 1; k_target = 64'h0000_0000_8000_0100;
    cycle();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL redir_req_low act=%b exp=0", o_req); end
    k_redir = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL redir_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
      if (o_vld) begin
        seen = 1;
        checks++; if (o_pc !== 64'h0000_0000_8000_0100) begin errors++; $display("FAIL redir_first_pc act=%h exp=80000100", o_pc); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL redir_timeout act=no_valid exp=valid"); end
  endtask

  task automatic test_redirect_coincident();
    bit seen = 0;
    bit found = 0;
    apply_reset();
    k_rdy = 1; k_redir = 0; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && m_out.size() > 0) found = 1;
      else cycle();
    end
    k_redir = 1; k_target = 64'h0000_0000_8000_0400;
    cycle();
    checks++; if (!(o_rv && o_vld)) begin errors++; $display("FAIL coinc_setup act=rv%b_vld%b exp=rv1_vld1", o_rv, o_vld); end
    k_redir = 0;
    cycle();
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL coinc_empty act=%b exp=0", o_vld); end
    checks++; if (o_pc !== 64'h0) begin errors++; $display("FAIL coinc_pc_zero act=%h exp=0", o_pc); end
    checks++; if (!(o_req && o_addr === 64'h0000_0000_8000_0400)) begin errors++; $display("FAIL coinc_refetch act=%b/%h exp=1/80000400", o_req, o_addr); end
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (o_vld) begin
        seen = 1;
        checks++; if (o_pc !== 64'h0000_0000_8000_0400) begin errors++; $display("FAIL coinc_first_pc act=%h exp=80000400", o_pc); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL coinc_timeout act=no_valid exp=valid"); end
  endtask

  task automatic test_gnt_withheld();
    apply_reset();
    k_rdy = 1; k_redir = 0; k_gnt_pct = 0; k_lat_min = 1; k_lat_max = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (!(o_req === 1'b1 && o_addr === RESET_PC)) begin errors++; $display("FAIL hold_c%0d act=%b/%h exp=1/%h", i, o_req, o_addr, RESET_PC); end
    end
    k_redir = 1; k_target = 64'h0000_0000_8000_0800;
    cycle();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL hold_retract act=%b exp=0", o_req); end
    k_redir = 0; k_gnt_pct = 100;
    cycle();
    checks++; if (!(o_req === 1'b1 && o_addr === 64'h0000_0000_8000_0800)) begin errors++; $display("FAIL hold_newaddr act=%b/%h exp=1/80000800", o_req, o_addr); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL hold_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_align_wrap();
    int g0;
    apply_reset();
    k_rdy = 1; k_redir = 0; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;
    for (int i = 0; i < 4; i++) cycle();
    k_redir = 1; k_target = 64'h0000_0000_8000_0103;
    cycle();
    k_redir = 0;
    cycle();
    checks++; if (!(o_req === 1'b1 && o_addr === 64'h0000_0000_8000_0100)) begin errors++; $display("FAIL align_addr act=%b/%h exp=1/80000100", o_req, o_addr); end
    for (int i = 0; i < 4; i++) cycle();
    k_redir = 1; k_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    k_redir = 0;
    g0 = granted.size();
    popped.delete();
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL wrap_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
    end
    checks++; if (granted.size() < g0 + 3) begin errors++; $display("FAIL wrap_grants act=%0d exp>=3", granted.size() - g0); end
    else begin
      checks++; if (granted[g0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 act=%h exp=fffffffffffffffc", granted[g0]); end
      checks++; if (granted[g0+1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1 act=%h exp=0", granted[g0+1]); end
      checks++; if (granted[g0+2] !== 64'h4) begin errors++; $display("FAIL wrap_addr2 act=%h exp=4", granted[g0+2]); end
    end
    checks++; if (popped.size() < 2) begin errors++; $display("FAIL wrap_pops act=%0d exp>=2", popped.size()); end
    else begin
      checks++; if (popped[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 act=%h exp=fffffffffffffffc", popped[0]); end
      checks++; if (popped[1] !== 64'h0) begin errors++; $display("FAIL wrap_pc1 act=%h exp=0", popped[1]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    k_rdy = 1; k_redir = 0; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;
    for (int i = 0; i < 6; i++) cycle();
    checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL midrst_busy act=%b exp=1", o_vld); end
    #3;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    checks++; if (bus.o_IMemReq !== 1'b0) begin errors++; $display("FAIL midrst_req act=%b exp=0", bus.o_IMemReq); end
    checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid act=%b exp=0", bus.o_Valid); end
    checks++; if (bus.o_PC_64 !== 64'h0) begin errors++; $display("FAIL midrst_pc act=%h exp=0", bus.o_PC_64); end
    checks++; if (bus.o_Inst_32 !== 32'h0) begin errors++; $display("FAIL midrst_inst act=%h exp=0", bus.o_Inst_32); end
    @(negedge clk);
    rst_n = 1'b1;
    k_rdy = 1;
    cycle();
    checks++; if (!(o_req === 1'b1 && o_addr === RESET_PC)) begin errors++; $display("FAIL midrst_restart act=%b/%h exp=1/%h", o_req, o_addr, RESET_PC); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL midrst_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    k_gnt_pct = 70; k_lat_min = 1; k_lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      k_rdy    = ($urandom_range(3) != 0);
      k_redir  = ($urandom_range(19) == 0);
      k_target = {$urandom, $urandom};
      cycle();
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_out c%0d act=%h exp=%h", i, obs_vec, exp_vec); end
    end
    k_redir = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_gnt_withheld();
    test_align_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
